// File: rtl/cache_write_buffer.sv
// Write-through store buffer: in-order FIFO drain to RAM plus a read-miss probe.
// Optional build macro WB_COALESCE_EN merges a store into a pending non-head entry of the same address.
module cache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    input  logic [ADDR_W-1:0]          rd_chk_addr,
    output logic                       rd_hit,
    output logic [DATA_W-1:0]          rd_hit_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    logic push, pop, alloc, coal_hit;
    logic [PTR_W-1:0] probe_idx;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never depends combinationally on ready, and payload is held while valid & !ready.
    assign mem_valid = (count_q != '0);
    assign mem_addr  = mem_valid ? addr_q[head_q] : '0;
    assign mem_data  = mem_valid ? data_q[head_q] : '0;
    assign count     = count_q;

    assign wr_ready = (count_q != FULL) | coal_hit;
    assign push     = wr_valid & wr_ready;
    assign alloc    = push & ~coal_hit;
    assign pop      = mem_valid & mem_ready;

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] coal_idx, coal_scan;

    // Head is skipped so its data stays stable while RAM may be sampling it.
    always_comb begin
        coal_hit  = 1'b0;
        coal_idx  = head_q;
        coal_scan = head_q;
        for (int i = 1; i < DEPTH; i++) begin
            coal_scan = head_q + PTR_W'(i);
            if (vld_q[coal_scan] && addr_q[coal_scan] == wr_addr) begin
                coal_hit = 1'b1;
                coal_idx = coal_scan;
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        rd_hit      = 1'b0;
        rd_hit_data = '0;
        probe_idx   = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            probe_idx = head_q + PTR_W'(i);
            if (vld_q[probe_idx] && addr_q[probe_idx] == rd_chk_addr) begin
                rd_hit      = 1'b1;
                rd_hit_data = data_q[probe_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            if (alloc) begin
                vld_q[tail_q]  <= 1'b1;
                addr_q[tail_q] <= wr_addr;
                data_q[tail_q] <= wr_data;
                tail_q         <= tail_q + PTR_W'(1);
            end
`ifdef WB_COALESCE_EN
            if (push && coal_hit) begin
                data_q[coal_idx] <= wr_data;
            end
`endif
            case ({alloc, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer: expected drain entries are queued by the stimulus
// and a negedge monitor pops and compares each RAM handshake.
module tb_cache_write_buffer;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] rd_chk_addr;
    logic        rd_hit;
    logic [31:0] rd_hit_data;
    logic [2:0]  count;

    logic [63:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    cache_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .rd_chk_addr(rd_chk_addr), .rd_hit(rd_hit), .rd_hit_data(rd_hit_data),
        .count(count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM handshake must match the next expected entry.
    always @(negedge clk) begin
        if (rst && mem_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL drain_unexpected: got 0x%0h/0x%0h expected nothing", mem_addr, mem_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("drain", {mem_addr, mem_data}, e);
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic expect_entry(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drain_all(input string name);
        bit done;
        done = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            if (count == 3'd0) done = 1'b1;
        end
        mem_ready = 1'b0;
        chk({name, "_done"}, {63'd0, done}, 64'd1);
        chk({name, "_mem_valid"}, {63'd0, mem_valid}, 64'd0);
        chk({name, "_exp_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        mem_ready = 1'b0; rd_chk_addr = '0;
        #12;
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        chk("rst_rd_hit", {63'd0, rd_hit}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        cyc();
        rst = 1'b1;
        cyc();

        // Fill to full with RAM stalled
        push(32'h1000, 32'h11);
        chk("first_latency_valid", {63'd0, mem_valid}, 64'd1);
        push(32'h1004, 32'h22);
        push(32'h1008, 32'h33);
        push(32'h100C, 32'h44);
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_wr_ready", {63'd0, wr_ready}, 64'd0);
        chk("full_head_addr", {32'd0, mem_addr}, 64'h1000);
        wr_valid = 1'b1; wr_addr = 32'h1010; wr_data = 32'h55;
        #1;
        chk("full_refuse_ready", {63'd0, wr_ready}, 64'd0);
        cyc();
        wr_valid = 1'b0;
        chk("full_refuse_count", {61'd0, count}, 64'd4);
        chk("stall_head_data", {32'd0, mem_data}, 64'h11);
        rd_chk_addr = 32'h1008;
        #1;
        chk("probe_a2_hit", {63'd0, rd_hit}, 64'd1);
        chk("probe_a2_data", {32'd0, rd_hit_data}, 64'h33);
        expect_entry(32'h1000, 32'h11);
        expect_entry(32'h1004, 32'h22);
        expect_entry(32'h1008, 32'h33);
        expect_entry(32'h100C, 32'h44);
        drain_all("fill_drain");

        // Simultaneous push and pop at count=2
        push(32'h2000, 32'h5);
        push(32'h2004, 32'h6);
        chk("pp_count_before", {61'd0, count}, 64'd2);
        expect_entry(32'h2000, 32'h5);
        expect_entry(32'h2004, 32'h6);
        expect_entry(32'h2008, 32'h7);
        mem_ready = 1'b1;
        push(32'h2008, 32'h7);
        mem_ready = 1'b0;
        chk("pp_count_after", {61'd0, count}, 64'd2);
        chk("pp_head_addr", {32'd0, mem_addr}, 64'h2004);
        drain_all("pp_drain");

        // Probe with duplicate addresses and same-cycle push visibility
        push(32'h100, 32'hAAAA);
        push(32'h100, 32'hBBBB);
        rd_chk_addr = 32'h100;
        #1;
        chk("probe_dup_hit", {63'd0, rd_hit}, 64'd1);
        chk("probe_dup_data", {32'd0, rd_hit_data}, 64'hBBBB);
        rd_chk_addr = 32'h104;
        #1;
        chk("probe_miss_hit", {63'd0, rd_hit}, 64'd0);
        chk("probe_miss_data", {32'd0, rd_hit_data}, 64'd0);
        rd_chk_addr = 32'h108;
        wr_valid = 1'b1; wr_addr = 32'h108; wr_data = 32'hD;
        #1;
        chk("probe_same_cycle_hit", {63'd0, rd_hit}, 64'd0);
        cyc();
        wr_valid = 1'b0;
        chk("probe_next_cycle_hit", {63'd0, rd_hit}, 64'd1);
        chk("probe_next_cycle_data", {32'd0, rd_hit_data}, 64'hD);
        chk("probe_count", {61'd0, count}, 64'd3);
        expect_entry(32'h100, 32'hAAAA);
        expect_entry(32'h100, 32'hBBBB);
        expect_entry(32'h108, 32'hD);
        drain_all("probe_drain");

        // Coalescing behaviour depends on the build
        push(32'h200, 32'h1);
        push(32'h300, 32'h2);
        push(32'h300, 32'h3);
`ifdef WB_COALESCE_EN
        chk("coal_count", {61'd0, count}, 64'd2);
        expect_entry(32'h200, 32'h1);
        expect_entry(32'h300, 32'h3);
`else
        chk("coal_count", {61'd0, count}, 64'd3);
        expect_entry(32'h200, 32'h1);
        expect_entry(32'h300, 32'h2);
        expect_entry(32'h300, 32'h3);
`endif
        drain_all("coal_drain");

        // Reset in the middle of a stalled drain
        push(32'h400, 32'h9);
        push(32'h404, 32'hA);
        push(32'h408, 32'hB);
        rd_chk_addr = 32'h404;
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("midrst_count", {61'd0, count}, 64'd0);
        chk("midrst_wr_ready", {63'd0, wr_ready}, 64'd1);
        chk("midrst_mem_data", {32'd0, mem_data}, 64'd0);
        chk("midrst_rd_hit", {63'd0, rd_hit}, 64'd0);
        cyc();
        rst = 1'b1;
        cyc();

        // Buffer is usable again after reset
        push(32'h500, 32'hE);
        chk("post_rst_count", {61'd0, count}, 64'd1);
        expect_entry(32'h500, 32'hE);
        drain_all("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
